reg_dump: RTL

Register-file dump engine for the processor wrapper on the board. On a start pulse it takes over the regfile's A read port through the test-mode mux and sweeps registers 0..NUM_REGS-1. It serializes each value MSB-first onto a valid/ready byte stream, framed by a header byte and an XOR checksum. It is the hardware counterpart of the bench's register-check pass: the host receives the same values the bench compares against `rN=value` expectations.

---
 rtl/reg_dump.sv | 135 +++++++++++++
 1 files changed

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - register-file dump engine: sweeps regfile port A onto a framed byte stream
module reg_dump #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        test_mode,
  output logic [4:0]  rs_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;

  localparam logic [4:0] LAST_SEL = 5'(NUM_REGS - 1);

  logic [2:0]  state_q,    state_d;
  logic [4:0]  rs_sel_q,   rs_sel_d;
  logic [31:0] shift_q,    shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  csum_q,     csum_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q,  tx_data_d;

  // tx_data_q always mirrors the byte on offer, so the stream outputs never see tx_ready directly.
  always_comb begin
    state_d    = state_q;
    rs_sel_d   = rs_sel_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          rs_sel_d   = 5'd0;
          csum_d     = 8'h00;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
        end
      end
      S_HDR: begin
        if (tx_ready) begin
          state_d    = S_SETTLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
      S_SETTLE: begin
        shift_d    = reg_data;
        byte_cnt_d = 2'd0;
        state_d    = S_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = reg_data[31:24];
      end
      S_SEND: begin
        if (tx_ready) begin
          csum_d = csum_q ^ tx_data_q;
          if (byte_cnt_q != 2'd3) begin
            shift_d    = {shift_q[23:0], 8'h00};
            byte_cnt_d = byte_cnt_q + 2'd1;
            tx_data_d  = shift_q[23:16];
          end else if (rs_sel_q == LAST_SEL) begin
            state_d   = S_CSUM;
            tx_data_d = csum_q ^ tx_data_q;
          end else begin
            rs_sel_d   = rs_sel_q + 5'd1;
            state_d    = S_SETTLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end
      end
      S_CSUM: begin
        if (tx_ready) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rs_sel_q   <= 5'd0;
      shift_q    <= 32'h0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rs_sel_q   <= rs_sel_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign busy      = busy_q;
  assign test_mode = busy_q;
  assign done      = done_q;
  assign rs_sel    = rs_sel_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;

endmodule
